// File: rtl/eth_dsp_pkg.sv
// Shared types and constants for the DSP-side sample pacer.
package eth_dsp_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} pacer_state_t;

   localparam int PREFETCH_DEPTH = 2;
   localparam int CNT_W          = $clog2(PREFETCH_DEPTH + 1);
   localparam int PTR_W          = $clog2(PREFETCH_DEPTH);

endpackage

// File: rtl/eth_dac_sample_pacer_if.sv
// Read port of a standard FIFO with 1-cycle read latency.
// master = the reader (pacer), slave = the FIFO side.
interface eth_dac_sample_pacer_if #(
   parameter int DATA_W = 32
) ();
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_rden;

   modport master (output fifo_rden, input fifo_empty, input fifo_rdata);
   modport slave  (input fifo_rden, output fifo_empty, output fifo_rdata);
endinterface

// File: rtl/eth_prefetch_buf.sv
// Two-entry prefetch buffer in front of a 1-cycle-latency FIFO.
// Tracks one outstanding read; its data is pushed the cycle after fifo_rden.
module eth_prefetch_buf
   import eth_dsp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              dsp_clock,
   input  logic              dsp_areset_n,
   input  logic              rd_allow,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              pop,
   output logic              fifo_rden,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count
);
   localparam int LVL_W = CNT_W + 1;

   logic [DATA_W-1:0] mem [PREFETCH_DEPTH];
   logic [PTR_W-1:0]  rptr, wptr;
   logic              in_flight;
   logic [LVL_W-1:0]  level_after;

   // occupancy once this cycle's landing read and pop are applied; a new
   // read is only issued if its data will have a slot to land in
   assign level_after = LVL_W'(count) + LVL_W'(in_flight) - LVL_W'(pop);
   assign fifo_rden   = rd_allow & ~fifo_empty & (level_after < LVL_W'(PREFETCH_DEPTH));
   assign head        = mem[rptr];

   // pointers, occupancy and outstanding-read flag
   always_ff @(posedge dsp_clock or negedge dsp_areset_n) begin
      if (!dsp_areset_n) begin
         rptr      <= '0;
         wptr      <= '0;
         count     <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= fifo_rden;
         if (in_flight) wptr <= wptr + PTR_W'(1);
         if (pop)       rptr <= rptr + PTR_W'(1);
         count <= CNT_W'(level_after);
      end
   end

   // storage needs no reset: an entry is only read after it was written
   always_ff @(posedge dsp_clock) begin
      if (in_flight) mem[wptr] <= fifo_rdata;
   end

endmodule

// File: rtl/eth_dac_sample_pacer.sv
// Paces DAC samples out of a prefetch buffer at a programmable interval
// (period+1 cycles) and counts strobes missed because the buffer ran dry.
module eth_dac_sample_pacer
   import eth_dsp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int PERIOD_W = 16,
   parameter int UFLOW_W  = 16
) (
   input  logic                 dsp_clock,
   input  logic                 dsp_areset_n,
   input  logic                 enable,
   input  logic [PERIOD_W-1:0]  period,
   eth_dac_sample_pacer_if.master fifo,
   output logic [DATA_W-1:0]    dac_data,
   output logic                 dac_data_valid_reg,
   output logic                 underflow,
   output logic [UFLOW_W-1:0]   underflow_count,
   output logic                 running
);
   pacer_state_t        state, state_nxt;
   logic [PERIOD_W-1:0] period_cnt, period_lat;
   logic                rd_allow, strobe_evt, pop, starve;
   logic [CNT_W-1:0]    buf_count;
   logic [DATA_W-1:0]   buf_head;

   assign strobe_evt = (state == RUN) && enable && (period_cnt == period_lat);
   assign pop        = strobe_evt && (buf_count != '0);
   assign starve     = strobe_evt && (buf_count == '0);

   eth_prefetch_buf #(.DATA_W(DATA_W)) u_buf (
      .dsp_clock    (dsp_clock),
      .dsp_areset_n (dsp_areset_n),
      .rd_allow     (rd_allow),
      .fifo_empty   (fifo.fifo_empty),
      .fifo_rdata   (fifo.fifo_rdata),
      .pop          (pop),
      .fifo_rden    (fifo.fifo_rden),
      .head         (buf_head),
      .count        (buf_count)
   );

   // state register
   always_ff @(posedge dsp_clock or negedge dsp_areset_n) begin
      if (!dsp_areset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   // next state: prime until full, run, re-prime on a missed strobe
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = PRIME;
         PRIME:   if (!enable) state_nxt = IDLE;
                  else if (buf_count == CNT_W'(PREFETCH_DEPTH)) state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
                  else if (starve) state_nxt = PRIME;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      running  = 1'b0;
      rd_allow = 1'b0;
      case (state)
         PRIME:   rd_allow = 1'b1;
         RUN:     begin running = 1'b1; rd_allow = 1'b1; end
         default: ;
      endcase
   end

   // interval counter; period is latched at RUN entry and at each strobe
   // so a change only applies from the next interval
   always_ff @(posedge dsp_clock or negedge dsp_areset_n) begin
      if (!dsp_areset_n) begin
         period_cnt <= '0;
         period_lat <= '0;
      end else begin
         if (state != RUN || strobe_evt) period_cnt <= '0;
         else                            period_cnt <= period_cnt + 1'b1;
         if ((state == PRIME && state_nxt == RUN) || strobe_evt) period_lat <= period;
      end
   end

   // registered sample strobe and underflow reporting
   always_ff @(posedge dsp_clock or negedge dsp_areset_n) begin
      if (!dsp_areset_n) begin
         dac_data           <= '0;
         dac_data_valid_reg <= 1'b0;
         underflow          <= 1'b0;
         underflow_count    <= '0;
      end else begin
         dac_data_valid_reg <= pop;
         underflow          <= starve;
         if (pop) dac_data <= buf_head;
         if (starve && underflow_count != '1) underflow_count <= underflow_count + 1'b1;
      end
   end

endmodule
